// File: rtl/mem_responder.sv
// Memory-side responder for the control unit's fetch/store port.
// Writes commit in one edge; reads complete RD_LAT cycles after accept with an en_ram_out pulse.
module mem_responder #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_ram_in,
  input  logic              en_str,
  input  logic              addr_sel,
  input  logic [AWIDTH-1:0] pc_addr,
  input  logic [AWIDTH-1:0] offset_addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata,
  output logic              en_ram_out,
  output logic              wr_done,
  output logic              busy,
  output logic              err
);

  localparam int         DEPTH    = 1 << AWIDTH;
  localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [2:0]        lat_cnt;
  logic [AWIDTH-1:0] addr, addr_q;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic              acc_wr, acc_rd, done, proto_err;

  assign addr = addr_sel ? offset_addr : pc_addr;

  // A write beats a simultaneous read; any request while a read is in flight is a protocol error.
  always_comb begin
    acc_wr    = (state == IDLE) && en_str;
    acc_rd    = (state == IDLE) && en_ram_in && !en_str;
    done      = (state == READ) && (lat_cnt == 3'd0);
    proto_err = ((state == IDLE) && en_ram_in && en_str) ||
                ((state == READ) && (en_ram_in || en_str));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc_rd) state_nxt = READ;
      READ:    if (done)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == READ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt    <= 3'd0;
      rdata      <= '0;
      en_ram_out <= 1'b0;
      wr_done    <= 1'b0;
      err        <= 1'b0;
    end else begin
      en_ram_out <= done;
      wr_done    <= acc_wr;
      if (proto_err) err <= 1'b1;
      if (acc_rd)
        lat_cnt <= LAT_INIT;
      else if ((state == READ) && (lat_cnt != 3'd0))
        lat_cnt <= lat_cnt - 3'd1;
      // Array is read at completion so a preceding write is always visible.
      if (done) rdata <= mem[addr_q];
    end
  end

  // Array contents and the captured address survive reset.
  always_ff @(posedge clk) begin
    if (acc_wr) mem[addr]  <= wdata;
    if (acc_rd) addr_q     <= addr;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one RD_LAT=2 instance and one RD_LAT=1 instance.
module tb_mem_responder;

  localparam int LAT_A = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          tests = 0;
  int          fails = 0;

  logic        en_ram_in = 1'b0, en_str = 1'b0, addr_sel = 1'b0;
  logic [7:0]  pc_addr = 8'h00, offset_addr = 8'h00;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic        en_ram_out, wr_done, busy, err;

  logic        b_en_ram_in = 1'b0, b_en_str = 1'b0, b_addr_sel = 1'b0;
  logic [7:0]  b_pc_addr = 8'h00, b_offset_addr = 8'h00;
  logic [15:0] b_wdata = 16'h0000;
  logic [15:0] b_rdata;
  logic        b_en_ram_out, b_wr_done, b_busy, b_err;

  always #5 clk = ~clk;

  mem_responder #(.DWIDTH(16), .AWIDTH(8), .RD_LAT(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .en_ram_in(en_ram_in), .en_str(en_str), .addr_sel(addr_sel),
    .pc_addr(pc_addr), .offset_addr(offset_addr), .wdata(wdata), .rdata(rdata),
    .en_ram_out(en_ram_out), .wr_done(wr_done), .busy(busy), .err(err)
  );

  mem_responder #(.DWIDTH(16), .AWIDTH(8), .RD_LAT(1)) dut_b (
    .clk(clk), .rst(rst), .en_ram_in(b_en_ram_in), .en_str(b_en_str), .addr_sel(b_addr_sel),
    .pc_addr(b_pc_addr), .offset_addr(b_offset_addr), .wdata(b_wdata), .rdata(b_rdata),
    .en_ram_out(b_en_ram_out), .wr_done(b_wr_done), .busy(b_busy), .err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_a(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    en_str = 1'b1; addr_sel = 1'b0; pc_addr = a; wdata = d;
    @(negedge clk);
    en_str = 1'b0;
    chk("wr_done", wr_done, 1);
  endtask

  task automatic rd_a(input logic sel, input logic [7:0] pc, input logic [7:0] off,
                      input logic [15:0] exp, input string tag);
    @(negedge clk);
    en_ram_in = 1'b1; addr_sel = sel; pc_addr = pc; offset_addr = off;
    for (int i = 0; i < LAT_A; i++) begin
      @(negedge clk);
      en_ram_in = 1'b0;
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_early"}, en_ram_out, 0);
    end
    @(negedge clk);
    chk({tag, "_vld"}, en_ram_out, 1);
    chk({tag, "_data"}, rdata, exp);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic wr_b(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    b_en_str = 1'b1; b_pc_addr = a; b_wdata = d;
    @(negedge clk);
    b_en_str = 1'b0;
    chk("b_wr_done", b_wr_done, 1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", rdata, 0);
    chk("rst_vld", en_ram_out, 0);
    chk("rst_wr_done", wr_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    // Write then read
    wr_a(8'h10, 16'hA5C3);
    rd_a(1'b0, 8'h10, 8'h00, 16'hA5C3, "wr_rd");
    @(negedge clk);
    chk("wr_rd_pulse_end", en_ram_out, 0);
    chk("wr_rd_hold", rdata, 16'hA5C3);
    chk("wr_done_pulse_end", wr_done, 0);

    // Address select
    wr_a(8'h20, 16'h1111);
    wr_a(8'h30, 16'h2222);
    chk("wr_keeps_rdata", rdata, 16'hA5C3);
    rd_a(1'b1, 8'h20, 8'h30, 16'h2222, "sel_off");
    rd_a(1'b0, 8'h20, 8'h30, 16'h1111, "sel_pc");
    chk("no_err_yet", err, 0);

    // Simultaneous read+write in IDLE: write wins, err set
    @(negedge clk);
    en_ram_in = 1'b1; en_str = 1'b1; addr_sel = 1'b0; pc_addr = 8'h05; wdata = 16'h00FF;
    @(negedge clk);
    en_ram_in = 1'b0; en_str = 1'b0;
    chk("sim_wr_done", wr_done, 1);
    chk("sim_err", err, 1);
    chk("sim_busy", busy, 0);
    repeat (2) begin
      @(negedge clk);
      chk("sim_no_vld", en_ram_out, 0);
    end
    rd_a(1'b0, 8'h05, 8'h00, 16'h00FF, "sim_mem");
    chk("sim_err_sticky", err, 1);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_clr_err", err, 0);
    chk("rst_clr_rdata", rdata, 0);

    // Collision while busy
    wr_a(8'h40, 16'h0BEE);
    @(negedge clk);
    en_ram_in = 1'b1; pc_addr = 8'h10; addr_sel = 1'b0;
    @(negedge clk);
    chk("col_busy", busy, 1);
    @(negedge clk);
    en_ram_in = 1'b0; en_str = 1'b1; pc_addr = 8'h40; wdata = 16'hDEAD;
    chk("col_err_rd", err, 1);
    chk("col_early", en_ram_out, 0);
    @(negedge clk);
    en_str = 1'b0;
    chk("col_vld", en_ram_out, 1);
    chk("col_data", rdata, 16'hA5C3);
    chk("col_no_wr", wr_done, 0);
    repeat (3) begin
      @(negedge clk);
      chk("col_no_extra", en_ram_out, 0);
    end
    rd_a(1'b0, 8'h40, 8'h00, 16'h0BEE, "col_mem");
    chk("col_err_sticky", err, 1);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    // Reset mid-read
    @(negedge clk);
    en_ram_in = 1'b1; pc_addr = 8'h10; addr_sel = 1'b0;
    @(negedge clk);
    en_ram_in = 1'b0;
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_busy_clr", busy, 0);
    chk("mid_rdata", rdata, 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mid_no_vld", en_ram_out, 0);
    end
    rd_a(1'b0, 8'h10, 8'h00, 16'hA5C3, "mid_after");

    // Back-to-back: new request in the en_ram_out cycle
    en_ram_in = 1'b1; pc_addr = 8'h30;
    @(negedge clk);
    en_ram_in = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_gap", en_ram_out, 0);
    @(negedge clk);
    chk("b2b_early", en_ram_out, 0);
    @(negedge clk);
    chk("b2b_vld", en_ram_out, 1);
    chk("b2b_data", rdata, 16'h2222);
    chk("b2b_err", err, 0);

    // RD_LAT=1 instance: three reads on alternate cycles
    wr_b(8'h00, 16'h1234);
    wr_b(8'h01, 16'h5678);
    wr_b(8'h02, 16'h9ABC);
    @(negedge clk);
    b_en_ram_in = 1'b1; b_pc_addr = 8'h00;
    @(negedge clk);
    b_en_ram_in = 1'b0;
    chk("l1_busy0", b_busy, 1);
    chk("l1_gap0", b_en_ram_out, 0);
    @(negedge clk);
    chk("l1_vld0", b_en_ram_out, 1);
    chk("l1_data0", b_rdata, 16'h1234);
    b_en_ram_in = 1'b1; b_pc_addr = 8'h01;
    @(negedge clk);
    b_en_ram_in = 1'b0;
    chk("l1_gap1", b_en_ram_out, 0);
    @(negedge clk);
    chk("l1_vld1", b_en_ram_out, 1);
    chk("l1_data1", b_rdata, 16'h5678);
    b_en_ram_in = 1'b1; b_pc_addr = 8'h02;
    @(negedge clk);
    b_en_ram_in = 1'b0;
    chk("l1_gap2", b_en_ram_out, 0);
    @(negedge clk);
    chk("l1_vld2", b_en_ram_out, 1);
    chk("l1_data2", b_rdata, 16'h9ABC);
    @(negedge clk);
    chk("l1_end", b_en_ram_out, 0);
    chk("l1_err", b_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
